// File: rtl/bin2bcd_scan_disp.sv
// bin2bcd_scan_disp: sequential double-dabble converter feeding a multiplexed 7-segment scanner.
// Define LZ_BLANK_EN to blank leading zero digits.
module bin2bcd_scan_disp #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 5,
  parameter int DIV_CNT    = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [DATA_W-1:0]     a,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            seg_led,
  output logic [NUM_DIGITS-1:0] seg_sel
);
  localparam int BW = 4 * NUM_DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int DW = $clog2(DIV_CNT);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] CLAST = CW'(DATA_W - 1);
  localparam logic [DW-1:0] DLAST = DW'(DIV_CNT - 1);
  localparam logic [IW-1:0] ILAST = IW'(NUM_DIGITS - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] bin;
  logic [BW-1:0] bcd, adj, disp;
  logic [CW-1:0] cnt;
  logic [DW-1:0] div;
  logic [IW-1:0] idx;
  logic [3:0] nib;
  logic blank;
  function automatic logic [7:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: seg7 = 8'hC0;
      4'd1: seg7 = 8'hF9;
      4'd2: seg7 = 8'hA4;
      4'd3: seg7 = 8'hB0;
      4'd4: seg7 = 8'h99;
      4'd5: seg7 = 8'h92;
      4'd6: seg7 = 8'h82;
      4'd7: seg7 = 8'hF8;
      4'd8: seg7 = 8'h80;
      4'd9: seg7 = 8'h90;
      default: seg7 = 8'hFF;
    endcase
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (en ? SHIFT : IDLE) :
               state == SHIFT ? (cnt == CLAST ? LATCH : SHIFT) : IDLE;
    busy = state != IDLE;
  end
  always_comb begin
    adj = bcd;
    for (int i = 0; i < NUM_DIGITS; i++)
      adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bin  <= '0;
      bcd  <= '0;
      cnt  <= '0;
      disp <= '0;
      done <= 1'b0;
    end else begin
      done <= state == LATCH;
      case (state)
        IDLE: if (en) begin
          bin <= a;
          bcd <= '0;
          cnt <= '0;
        end
        SHIFT: begin
          bcd <= {adj[BW-2:0], bin[DATA_W-1]};
          bin <= bin << 1;
          cnt <= cnt + 1'b1;
        end
        LATCH: disp <= bcd;
        default: ;
      endcase
    end
  // A digit is blank when it and everything above it is zero; digit 0 never blanks.
  always_comb begin
    nib = 4'(disp >> (4 * idx));
`ifdef LZ_BLANK_EN
    blank = idx != '0 && (disp >> (4 * idx)) == '0;
`else
    blank = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      div     <= '0;
      idx     <= '0;
      seg_sel <= ~NUM_DIGITS'(1);
      seg_led <= 8'hC0;
    end else begin
      div     <= div == DLAST ? '0 : div + 1'b1;
      idx     <= div != DLAST ? idx : idx == ILAST ? '0 : idx + 1'b1;
      seg_sel <= ~(NUM_DIGITS'(1) << idx);
      seg_led <= blank ? 8'hFF : seg7(nib);
    end
endmodule

// File: tb/tb_bin2bcd_scan_disp.sv
// tb_bin2bcd_scan_disp: table-driven and randomized checks of conversion, scanning and reset abort.
module tb_bin2bcd_scan_disp;
  logic clk = 0, rst = 1, en = 0;
  logic [15:0] a = '0;
  logic busy, done;
  logic [7:0] seg_led;
  logic [4:0] seg_sel;
  int checks = 0, errors = 0;
  localparam logic [7:0] SEG [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  typedef struct { logic [15:0] a; logic [39:0] nlz; logic [39:0] lz; } vec_t;
  vec_t vecs [5];
  bin2bcd_scan_disp #(.DATA_W(16), .NUM_DIGITS(5), .DIV_CNT(4)) dut (
    .clk(clk), .rst(rst), .en(en), .a(a), .busy(busy), .done(done),
    .seg_led(seg_led), .seg_sel(seg_sel)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask
  // Expected display image, digit i in bits [8i+7:8i], from decimal arithmetic.
  function automatic logic [39:0] model(input int v);
    logic [39:0] r = '0;
    int p = 1;
    bit lz;
`ifdef LZ_BLANK_EN
    lz = 1;
`else
    lz = 0;
`endif
    for (int i = 0; i < 5; i++) begin
      r[8*i +: 8] = (lz && i > 0 && v < p) ? 8'hFF : SEG[(v / p) % 10];
      p *= 10;
    end
    return r;
  endfunction
  task automatic convert(input logic [15:0] v);
    int bc = 0;
    bit seen = 0;
    @(negedge clk); a = v; en = 1;
    @(negedge clk); en = 0;
    for (int i = 0; i < 40 && !seen; i++)
      if (done) seen = 1;
      else begin
        if (busy) bc++;
        @(negedge clk);
      end
    chk("done_seen", 64'(seen), 1);
    chk("busy_cycles", 64'(bc), 17);
    chk("busy_low_at_done", 64'(busy), 0);
    @(negedge clk);
    chk("done_pulse_width", 64'(done), 0);
  endtask
  task automatic read_disp(output logic [39:0] got);
    int bad = 0;
    got = '0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (!$onehot(~seg_sel)) bad++;
      for (int j = 0; j < 5; j++)
        if (seg_sel == ~(5'b1 << j)) got[8*j +: 8] = seg_led;
    end
    chk("sel_onehot_low", 64'(bad), 0);
  endtask
  task automatic wait_done(output bit seen);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    chk("wait_done", 64'(seen), 1);
  endtask
  initial begin
    logic [39:0] got;
    logic [4:0] prev, exp_sel;
    int gap, nd;
    bit seen;
    vecs[0] = '{16'd65535, 40'h82_92_92_B0_92, 40'h82_92_92_B0_92};
    vecs[1] = '{16'd42,    40'hC0_C0_C0_99_A4, 40'hFF_FF_FF_99_A4};
    vecs[2] = '{16'd0,     40'hC0_C0_C0_C0_C0, 40'hFF_FF_FF_FF_C0};
    vecs[3] = '{16'd10000, 40'hF9_C0_C0_C0_C0, 40'hF9_C0_C0_C0_C0};
    vecs[4] = '{16'd9,     40'hC0_C0_C0_C0_90, 40'hFF_FF_FF_FF_90};
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    chk("rst_sel", 64'(seg_sel), 64'h1E);
    chk("rst_led", 64'(seg_led), 64'hC0);
    rst = 0;
    prev = 5'b11110;
    for (int k = 0; k < 6; k++) begin
      gap = 0;
      while (seg_sel == prev && gap < 12) begin
        @(negedge clk);
        gap++;
      end
      exp_sel = ~(5'b1 << ((k + 1) % 5));
      chk("scan_order", 64'(seg_sel), 64'(exp_sel));
      if (k > 0) chk("scan_gap", 64'(gap), 4);
      prev = seg_sel;
    end
    foreach (vecs[i]) begin
      convert(vecs[i].a);
      read_disp(got);
`ifdef LZ_BLANK_EN
      chk("vec_disp", 64'(got), 64'(vecs[i].lz));
`else
      chk("vec_disp", 64'(got), 64'(vecs[i].nlz));
`endif
    end
    for (int r = 0; r < 20; r++) begin
      logic [15:0] v;
      v = 16'($urandom_range(0, 65535));
      convert(v);
      read_disp(got);
      chk("rand_disp", 64'(got), 64'(model(int'(v))));
    end
    @(negedge clk); a = 16'd1234; en = 1;
    @(negedge clk); en = 0;
    repeat (4) @(negedge clk);
    chk("busy_at_cycle5", 64'(busy), 1);
    a = 16'd999; en = 1;
    @(negedge clk); en = 0;
    nd = 0;
    repeat (60) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("ignored_en_dones", 64'(nd), 1);
    read_disp(got);
    chk("ignored_en_disp", 64'(got), 64'(model(1234)));
    @(negedge clk); a = 16'd12; en = 1;
    @(negedge clk); en = 0;
    wait_done(seen);
    a = 16'd34; en = 1;
    @(negedge clk); en = 0;
    chk("b2b_busy", 64'(busy), 1);
    wait_done(seen);
    read_disp(got);
    chk("b2b_disp", 64'(got), 64'(model(34)));
    convert(16'd7);
    @(negedge clk); a = 16'd500; en = 1;
    @(negedge clk); en = 0;
    repeat (7) @(negedge clk);
    chk("abort_busy_before", 64'(busy), 1);
    rst = 1;
    #1;
    chk("abort_busy", 64'(busy), 0);
    chk("abort_done", 64'(done), 0);
    nd = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) nd++;
    end
    rst = 0;
    repeat (30) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 64'(nd), 0);
    read_disp(got);
    chk("abort_disp", 64'(got), 64'(model(0)));
    convert(16'd321);
    read_disp(got);
    chk("after_abort_disp", 64'(got), 64'(model(321)));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/bin2bcd_scan_disp.md
BIN2BCD_SCAN_DISP -- requirements
Module: bin2bcd_scan_disp

Interface
REQ-001 Parameter DATA_W, default 16, width of the binary input.
REQ-002 Parameter NUM_DIGITS, default 5, number of BCD digits and display positions; SHALL be >= ceil(DATA_W*log10(2)).
REQ-003 Parameter DIV_CNT, default 50000, clocks per digit scan slot (>= 2).
REQ-004 clk  in  1  single system clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, asynchronous and active-high.
REQ-006 en  in  1  load strobe; requests conversion of a.
REQ-007 a  in  DATA_W  unsigned binary value to convert.
REQ-008 busy  out  1  high while a conversion is in progress.
REQ-009 done  out  1  one-cycle pulse when the display register is updated.
REQ-010 seg_led  out  8  active-low segments {dp,g,f,e,d,c,b,a} of the selected digit.
REQ-011 seg_sel  out  NUM_DIGITS  active-low one-hot digit select; bit 0 = least significant digit.

Function
REQ-012 FSM states IDLE, SHIFT and LATCH; the converter SHALL be sequential double-dabble (add-3 then shift-left), one bit per clock.
REQ-013 IDLE: en=1 at a rising edge SHALL capture a, clear the BCD accumulator, set busy=1 and go to SHIFT.
REQ-014 SHIFT: each clock, every BCD nibble >= 5 gets +3, then {bcd,bin} shift left by 1; after exactly DATA_W iterations go to LATCH.
REQ-015 LATCH: the display register gets the accumulator, done=1 for one cycle, busy=0, next state IDLE.
REQ-016 Latency: done SHALL be high in the cycle following the (DATA_W+1)th edge after the capture edge; busy is high for DATA_W+1 cycles.
REQ-017 en while busy=1 SHALL be ignored; a and en are not sampled again until IDLE.
REQ-018 en=1 in the cycle done=1 SHALL be accepted (FSM is already IDLE); back-to-back conversions are allowed.
REQ-019 The display register SHALL change only in LATCH; scanning shows the last completed result throughout a conversion.
REQ-020 Scan divider counts 0..DIV_CNT-1; at terminal count it wraps to 0 and the digit index increments, wrapping NUM_DIGITS-1 -> 0.
REQ-021 seg_sel SHALL drive low only the bit at the digit index; seg_led SHALL show that digit from the display register.
REQ-022 Segment codes SHALL be 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90 (hex); dp (bit 7) SHALL always be 1; nibbles 10-15 SHALL give FF.
REQ-023 Outputs seg_led and seg_sel SHALL be registered (one-clock delay from index and register values).

Reset
REQ-024 rst=1 SHALL immediately force FSM=IDLE, busy=0, done=0, accumulator=0, display register=0, divider=0 and digit index=0.
REQ-025 During and after reset, seg_sel SHALL be all ones except bit 0 = 0, and seg_led SHALL be C0.
REQ-026 rst during SHIFT or LATCH SHALL abort the conversion with no done pulse; the display register SHALL read 0.

Configuration
REQ-027 Macro LZ_BLANK_EN SHALL enable leading-zero blanking.
REQ-028 With LZ_BLANK_EN defined, every digit above the most significant nonzero digit SHALL show FF; digit 0 SHALL always be shown, so value 0 displays one "0".
REQ-029 Without LZ_BLANK_EN, all NUM_DIGITS digits SHALL be shown, including leading zeros (C0).

Verification (DATA_W=16, NUM_DIGITS=5, DIV_CNT=4 unless stated)
REQ-030 Apply rst -> busy=0, done=0, seg_sel=11110, seg_led=C0.
REQ-031 en pulse with a=65535 -> busy high 17 cycles; done pulse; scanning digits 0..4 shows 92,B0,92,92,82 (5,3,5,5,6).
REQ-032 en with a=1234, then en with a=999 on cycle 5 of busy -> second request ignored; display shows 1234; exactly one done pulse.
REQ-033 a=42, LZ_BLANK_EN defined -> digits 0,1 show A4,99 and digits 2-4 show FF; macro undefined -> digits 2-4 show C0.
REQ-034 Free-run after reset -> seg_sel changes every 4 clocks in order 11110,11101,11011,10111,01111, then back to 11110.
REQ-035 Load 7, then start a=500 and assert rst on the 8th SHIFT cycle -> busy=0 immediately, no done pulse, display shows 0; a new en after release converts normally.
